// File: rtl/cv32e41s_sffr_monitor.sv
// ============================================================================
// cv32e41s_sffr_monitor: scans true/shadow flop pairs one bit per cycle, filters
// transient non-complementary pairs and raises minor/sticky major alerts. Rev 1.0
// ============================================================================
`default_nettype none

module cv32e41s_sffr_monitor #(
  parameter int WIDTH  = 8,
  parameter int FILTER = 2,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] q_shadow_i,
  input  logic             alert_clear_i,
  output logic [IW-1:0]    scan_idx_o,
  output logic             scan_done_o,
  output logic             alert_minor_o,
  output logic             alert_major_o,
  output logic             fault_valid_o,
  output logic [IW-1:0]    fault_idx_o
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CW-1:0] FILTER_C = CW'(FILTER);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_CONFIRM = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          sampling;
  logic          mismatch;

  assign sampling   = (state == S_SCAN) || (state == S_CONFIRM);
  // A healthy pair is complementary, so equal bits indicate a fault.
  assign mismatch   = sampling && (q_i[idx] == q_shadow_i[idx]);
  assign cnt_inc    = cnt + CW'(1);
  assign scan_idx_o = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      scan_done_o   <= 1'b0;
      alert_minor_o <= 1'b0;
      alert_major_o <= 1'b0;
      fault_valid_o <= 1'b0;
      fault_idx_o   <= '0;
    end else begin
      scan_done_o   <= 1'b0;
      alert_minor_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en_i) begin
            state <= S_SCAN;
            idx   <= '0;
          end
        end
        S_SCAN, S_CONFIRM: begin
          if (mismatch) begin
            alert_minor_o <= 1'b1;
            if ((state == S_SCAN) && (FILTER > 1)) begin
              cnt   <= CW'(1);
              state <= S_CONFIRM;
            end else if ((state == S_CONFIRM) && (cnt_inc != FILTER_C)) begin
              cnt <= cnt_inc;
            end else begin
              cnt           <= FILTER_C;
              state         <= S_LOCKED;
              alert_major_o <= 1'b1;
              fault_valid_o <= 1'b1;
              fault_idx_o   <= idx;
            end
          end else begin
            // A clean resample in CONFIRM resumes exactly like a clean scan step.
            cnt   <= '0;
            state <= S_SCAN;
            if (idx == LAST_IDX) begin
              idx         <= '0;
              scan_done_o <= 1'b1;
              if (!en_i) begin
                state <= S_IDLE;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_LOCKED: begin
          if (alert_clear_i) begin
            state         <= S_IDLE;
            idx           <= '0;
            cnt           <= '0;
            alert_major_o <= 1'b0;
            fault_valid_o <= 1'b0;
            fault_idx_o   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cv32e41s_sffr_monitor.sv
// Directed bench for cv32e41s_sffr_monitor with FILTER=2 and FILTER=1 instances.
`default_nettype none

module tb_cv32e41s_sffr_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       en1;
  logic [7:0] q;
  logic [7:0] sh;
  logic       clr;

  logic [2:0] idx0, fidx0, idx1, fidx1;
  logic       done0, minor0, major0, valid0;
  logic       done1, minor1, major1, valid1;
  logic [9:0] o0, o1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e41s_sffr_monitor #(.WIDTH(8), .FILTER(2)) dut (
    .clk(clk), .rst(rst), .en_i(en), .q_i(q), .q_shadow_i(sh),
    .alert_clear_i(clr), .scan_idx_o(idx0), .scan_done_o(done0),
    .alert_minor_o(minor0), .alert_major_o(major0),
    .fault_valid_o(valid0), .fault_idx_o(fidx0)
  );

  cv32e41s_sffr_monitor #(.WIDTH(8), .FILTER(1)) dut1 (
    .clk(clk), .rst(rst), .en_i(en1), .q_i(q), .q_shadow_i(sh),
    .alert_clear_i(clr), .scan_idx_o(idx1), .scan_done_o(done1),
    .alert_minor_o(minor1), .alert_major_o(major1),
    .fault_valid_o(valid1), .fault_idx_o(fidx1)
  );

  assign o0 = {idx0, done0, minor0, major0, valid0, fidx0};
  assign o1 = {idx1, done1, minor1, major1, valid1, fidx1};

  // Packed layout: {scan_idx, done, minor, major, valid, fault_idx}
  function automatic logic [9:0] pk(input int i, input bit d, input bit mi,
                                    input bit ma, input bit v, input int f);
    return {i[2:0], d, mi, ma, v, f[2:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a pass with a one-cycle enable pulse; afterwards idx 0 is being sampled.
  task automatic start_pass();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en1 = 1'b0; q = 8'hA5; sh = 8'h5A; clr = 1'b0;
    tick();
    check("reset_dut", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));
    check("reset_dut1", 32'(o1), 32'(pk(0, 0, 0, 0, 0, 0)));
    rst = 1'b0;

    // Clean pass
    start_pass();
    check("clean_idx0", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("clean_idx%0d", i), 32'(o0), 32'(pk(i, 0, 0, 0, 0, 0)));
    end
    tick();
    check("clean_done", 32'(o0), 32'(pk(0, 1, 0, 0, 0, 0)));
    tick();
    check("clean_idle1", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));
    tick();
    check("clean_idle2", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));

    // Transient fault at bit 3 for one sample
    start_pass();
    repeat (3) tick();
    check("trans_at3", 32'(o0), 32'(pk(3, 0, 0, 0, 0, 0)));
    sh = 8'h52;
    tick();
    sh = 8'h5A;
    check("trans_minor", 32'(o0), 32'(pk(3, 0, 1, 0, 0, 0)));
    tick();
    check("trans_resume4", 32'(o0), 32'(pk(4, 0, 0, 0, 0, 0)));
    repeat (3) tick();
    check("trans_at7", 32'(o0), 32'(pk(7, 0, 0, 0, 0, 0)));
    tick();
    check("trans_done", 32'(o0), 32'(pk(0, 1, 0, 0, 0, 0)));

    // Persistent fault at bit 5
    sh = 8'h7A;
    start_pass();
    repeat (5) tick();
    check("pers_at5", 32'(o0), 32'(pk(5, 0, 0, 0, 0, 0)));
    tick();
    check("pers_minor1", 32'(o0), 32'(pk(5, 0, 1, 0, 0, 0)));
    tick();
    check("pers_major", 32'(o0), 32'(pk(5, 0, 1, 1, 1, 5)));
    for (int i = 0; i < 20; i++) begin
      en = i[0];
      tick();
      check($sformatf("pers_hold%0d", i), 32'({idx0, done0, major0, valid0, fidx0}),
            32'({3'd5, 1'b0, 1'b1, 1'b1, 3'd5}));
    end
    en = 1'b0;
    sh = 8'h5A;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("pers_cleared", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));
    tick();
    check("pers_idle", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));

    // alert_clear in SCAN, then fault at idx 7 with en low
    start_pass();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_in_scan", 32'(o0), 32'(pk(1, 0, 0, 0, 0, 0)));
    repeat (6) tick();
    check("b7_at7", 32'(o0), 32'(pk(7, 0, 0, 0, 0, 0)));
    sh = 8'hDA;
    tick();
    sh = 8'h5A;
    check("b7_minor", 32'(o0), 32'(pk(7, 0, 1, 0, 0, 0)));
    tick();
    check("b7_wrap_done", 32'(o0), 32'(pk(0, 1, 0, 0, 0, 0)));
    tick();
    check("b7_idle", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));

    // Continuous mode: next pass starts at idx 0 right after the wrap
    en = 1'b1;
    tick();
    repeat (7) tick();
    check("cont_at7", 32'(o0), 32'(pk(7, 0, 0, 0, 0, 0)));
    tick();
    check("cont_done", 32'(o0), 32'(pk(0, 1, 0, 0, 0, 0)));
    tick();
    check("cont_idx1", 32'(o0), 32'(pk(1, 0, 0, 0, 0, 0)));
    en = 1'b0;
    repeat (6) tick();
    check("cont_at7b", 32'(o0), 32'(pk(7, 0, 0, 0, 0, 0)));
    tick();
    check("cont_done2", 32'(o0), 32'(pk(0, 1, 0, 0, 0, 0)));
    tick();
    check("cont_idle", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));

    // Reset in the middle of CONFIRM
    start_pass();
    tick();
    sh = 8'h58;
    tick();
    check("rstc_minor", 32'(o0), 32'(pk(1, 0, 1, 0, 0, 0)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sh = 8'h5A;
    check("rstc_reset", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));
    tick();
    check("rstc_idle", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));
    start_pass();
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("rstc_scan%0d", i), 32'(o0), 32'(pk(i, 0, 0, 0, 0, 0)));
    end
    tick();
    check("rstc_done", 32'(o0), 32'(pk(0, 1, 0, 0, 0, 0)));

    // FILTER=1 instance, fault at last index
    sh = 8'hDA;
    en1 = 1'b1;
    tick();
    en1 = 1'b0;
    repeat (7) tick();
    check("f1_at7", 32'(o1), 32'(pk(7, 0, 0, 0, 0, 0)));
    tick();
    check("f1_lock", 32'(o1), 32'(pk(7, 0, 1, 1, 1, 7)));
    check("f1_main_idle", 32'(o0), 32'(pk(0, 0, 0, 0, 0, 0)));
    tick();
    check("f1_hold", 32'({idx1, done1, major1, valid1, fidx1}),
          32'({3'd7, 1'b0, 1'b1, 1'b1, 3'd7}));
    sh = 8'h5A;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("f1_cleared", 32'(o1), 32'(pk(0, 0, 0, 0, 0, 0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
